slave_out_tx: RTL

//   Slave-side read-data transmitter: the sending end of the serial read path into the master input port.
//   On a read request from slave control, fetches burst_num+1 words from local memory (addresses rd_addr upward)
//   and sends them after a valid/ready handshake. Serial output, LSB first, one bit per clk, words back to back.

---
 rtl/slave_out_tx_pkg.sv | 7 +
 rtl/slave_out_tx_if.sv | 26 ++
 rtl/slave_out_tx_piso_shift.sv | 18 +
 rtl/slave_out_tx.sv | 110 +++++++++++
 4 files changed

// File: rtl/slave_out_tx_pkg.sv
// slave_out_tx_pkg: shared state encoding and default widths for the serial read path.
package slave_out_tx_pkg;
    localparam int DATA_LEN_DEF  = 8;
    localparam int ADDR_LEN_DEF  = 12;
    localparam int BURST_LEN_DEF = 12;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, HANDSHAKE, SEND} state_e;
endpackage

// File: rtl/slave_out_tx_if.sv
// slave_out_tx_if: request, memory and serial handshake signals of the read-data transmitter.
interface slave_out_tx_if import slave_out_tx_pkg::*; #(
    parameter int DATA_LEN  = DATA_LEN_DEF,
    parameter int ADDR_LEN  = ADDR_LEN_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) ();
    logic                 rd_req;
    logic [ADDR_LEN-1:0]  rd_addr;
    logic [BURST_LEN-1:0] burst_num;
    logic                 master_ready;
    logic [DATA_LEN-1:0]  mem_rdata;
    logic                 mem_rd_en;
    logic [ADDR_LEN-1:0]  mem_addr;
    logic                 slave_valid;
    logic                 tx_data;
    logic                 tx_done;
    logic                 busy;
    modport slave (
        input  rd_req, rd_addr, burst_num, master_ready, mem_rdata,
        output mem_rd_en, mem_addr, slave_valid, tx_data, tx_done, busy
    );
    modport master (
        output rd_req, rd_addr, burst_num, master_ready, mem_rdata,
        input  mem_rd_en, mem_addr, slave_valid, tx_data, tx_done, busy
    );
endinterface

// File: rtl/slave_out_tx_piso_shift.sv
// piso_shift: parallel-load, right-shift register; load wins over shift.
module piso_shift #(
    parameter int DATA_LEN = slave_out_tx_pkg::DATA_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                shift_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic                bit_o
);
    logic [DATA_LEN-1:0] q_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q_q <= '0;
        else if (load_i) q_q <= data_i;
        else if (shift_i) q_q <= q_q >> 1;
    assign bit_o = q_q[0];
endmodule

// File: rtl/slave_out_tx.sv
// slave_out_tx: fetches burst_num+1 words from local memory and streams them LSB first after a valid/ready handshake.
module slave_out_tx import slave_out_tx_pkg::*; #(
    parameter int DATA_LEN  = DATA_LEN_DEF,
    parameter int ADDR_LEN  = ADDR_LEN_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input logic           clk,
    input logic           rst_n,
    slave_out_tx_if.slave bus
);
    localparam int BW = $clog2(DATA_LEN);
    state_e               state_q, state_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [BURST_LEN-1:0] burst_q, burst_d, word_q, word_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_LEN-1:0]  pf_q, pf_d, sr_din;
    logic                 tx_q, tx_d, done_q, done_d, sr_load, sr_shift, sr_bit, last_bit, more;
    piso_shift #(.DATA_LEN(DATA_LEN)) u_piso (
        .clk(clk), .rst_n(rst_n), .load_i(sr_load), .shift_i(sr_shift), .data_i(sr_din), .bit_o(sr_bit)
    );
    assign last_bit        = bit_q == BW'(DATA_LEN - 1);
    assign more            = word_q < burst_q;
    assign bus.slave_valid = state_q == HANDSHAKE;
    assign bus.busy        = state_q != IDLE;
    assign bus.tx_data     = tx_q;
    assign bus.tx_done     = done_q;
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        burst_d       = burst_q;
        word_d        = word_q;
        bit_d         = bit_q;
        pf_d          = pf_q;
        tx_d          = tx_q;
        done_d        = 1'b0;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        sr_din        = bus.mem_rdata;
        bus.mem_rd_en = 1'b0;
        bus.mem_addr  = '0;
        case (state_q)
            IDLE: if (bus.rd_req) begin
                addr_d  = bus.rd_addr;
                burst_d = bus.burst_num;
                word_d  = '0;
                bit_d   = '0;
                state_d = FETCH;
            end
            FETCH: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = addr_q;
                state_d       = LOAD;
            end
            LOAD: begin
                sr_load = 1'b1;
                state_d = HANDSHAKE;
            end
            HANDSHAKE: if (bus.master_ready) begin
                tx_d     = sr_bit;
                sr_shift = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
                if (bit_q == '0 && more) begin
                    bus.mem_rd_en = 1'b1;
                    bus.mem_addr  = addr_q + ADDR_LEN'(1);
                    addr_d        = addr_q + ADDR_LEN'(1);
                end
                if (bit_q == BW'(1) && more) pf_d = bus.mem_rdata;
                // pf_d (not pf_q) so a 2-bit word can switch in the same cycle the prefetch lands
                if (!last_bit) begin
                    tx_d     = sr_bit;
                    sr_shift = 1'b1;
                    bit_d    = bit_q + BW'(1);
                end else if (more) begin
                    tx_d    = pf_d[0];
                    sr_din  = pf_d >> 1;
                    sr_load = 1'b1;
                    word_d  = word_q + BURST_LEN'(1);
                    bit_d   = '0;
                end else begin
                    tx_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            pf_q    <= '0;
            tx_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            pf_q    <= pf_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
endmodule
